// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch stage and the instruction memory.
// The fetch stage is the master: it drives the request and the address. The memory answers
// with ready and the instruction word.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage. It holds the PC and fetches from a variable-latency memory.
// It keeps the returned word until the core retires it, then picks the next PC from the
// JR/Jump/PCSrc controls. A misaligned target halts the stage with a sticky fault until reset.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master imem,
    output logic [31:0]  instr,
    output logic         instr_valid,
    output logic [31:0]  pc,
    output logic [31:0]  pc_plus4,
    input  logic         advance,
    input  logic         PCSrc,
    input  logic         Jump,
    input  logic         JR,
    input  logic [31:0]  rs_data,
    output logic         fault,
    output logic [31:0]  retired
);

    typedef enum logic [1:0] {
        StFetch,
        StHold,
        StHalt
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retired_q, retired_d;
    logic        fault_q, fault_d;

    logic [31:0] link;
    logic [31:0] branch_off;
    logic [31:0] next_pc;

    // Candidate next PC, resolved by priority JR > Jump > PCSrc > sequential.
    always_comb begin
        link       = pc_q + 32'd4;
        branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        if (JR) begin
            next_pc = rs_data;
        end else if (Jump) begin
            next_pc = {link[31:28], instr_q[25:0], 2'b00};
        end else if (PCSrc) begin
            next_pc = link + branch_off;
        end else begin
            next_pc = link;
        end
    end

    // Next-state logic: accept a memory response in FETCH, and retire plus redirect in HOLD.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        fault_d   = fault_q;
        unique case (state_q)
            StFetch: begin
                if (imem.imem_ready) begin
                    instr_d = imem.imem_rdata;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (advance) begin
                    pc_d      = next_pc;
                    retired_d = retired_q + 32'd1;
                    if (next_pc[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                        state_d = StHalt;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            StHalt: begin
                // Parked until reset; every input is ignored.
            end
            default: begin
                state_d = StHalt;
                fault_d = 1'b1;
            end
        endcase
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            retired_q <= 32'd0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
            fault_q   <= fault_d;
        end
    end

    // Outputs decode only registered state, so imem_ready has no path to the request.
    always_comb begin
        imem.imem_req  = (state_q == StFetch);
        imem.imem_addr = pc_q;
        instr_valid    = (state_q == StHold);
        instr          = instr_q;
        pc             = pc_q;
        pc_plus4       = link;
        fault          = fault_q;
        retired        = retired_q;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that sits directly upstream of the control unit in the MIPS core. It holds the program counter and issues requests to a variable-latency instruction memory. It latches the returned instruction and presents it to decode/control, where Opcode = instr[31:26] and Func = instr[5:0]. When the core retires the instruction, it computes the next PC from the control outputs PCSrc, Jump and JR, and it raises a sticky fault on misaligned targets.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word-aligned)
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- imem_req  out  1  fetch request, high in FETCH state
- imem_addr  out  32  equals pc
- imem_ready  in  1  memory returns imem_rdata this cycle (sampled only while imem_req=1)
- imem_rdata  in  32  instruction word
- instr  out  32  latched instruction, fed to control/decode
- instr_valid  out  1  instr is valid and awaiting retirement
- pc  out  32  address of current instruction
- pc_plus4  out  32  pc + 4 (JAL link value)
- advance  in  1  core retires instr this cycle; next-PC controls valid
- PCSrc  in  1  branch taken (from control)
- Jump  in  1  J/JAL
- JR  in  1  jump register
- rs_data  in  32  JR target
- fault  out  1  sticky misaligned-target flag
- retired  out  32  count of retired instructions

## Operation
- States: FETCH, HOLD, HALT. Reset → FETCH.
- FETCH: imem_req=1, imem_addr=pc. Edge with imem_ready=1: instr←imem_rdata, instr_valid←1, go to HOLD. Otherwise stay (unbounded wait states).
- HOLD: imem_req=0, instr stable. Edge with advance=1: compute next_pc, instr_valid←0, retired←retired+1 (mod 2^32, wraps to 0). If next_pc[1:0]≠0: pc←next_pc, fault←1, go to HALT. Else pc←next_pc, go to FETCH. advance=0: hold everything.
- HALT: imem_req=0, instr_valid=0. All inputs ignored until reset.
- next_pc priority: JR → rs_data; else Jump → {pc_plus4[31:28], instr[25:0], 2'b00}; else PCSrc → pc_plus4 + (sign-extended instr[15:0] << 2); else pc_plus4. All arithmetic is 32-bit modulo; carries are discarded, so 32'hFFFF_FFFC + 4 = 0.
- Multiple of JR/Jump/PCSrc high together is legal and resolved by the priority above.
- advance in FETCH or HALT is ignored. Control inputs are sampled only on the advance edge.
- imem_ready while imem_req=0 is ignored.

## Timing
- Reset values: pc=RESET_PC, instr=0, instr_valid=0, fault=0, retired=0, state=FETCH, so imem_req=1 immediately after reset release. pc_plus4=RESET_PC+4.
- imem_req and imem_addr are decoded from registered state/pc (no combinational path from imem_ready).
- Latency: request in cycle N with imem_ready=1 → instr_valid=1 in cycle N+1. advance in N+1 → new imem_req/imem_addr in N+2. Peak throughput is 1 instruction per 2 cycles.
- Async reset mid-FETCH or mid-HOLD: outputs return to reset values without waiting for a clock. A memory response in the reset cycle is discarded, and the first fetch after release is RESET_PC.
- fault asserts the cycle after the faulting advance edge and stays high until reset.

## Test plan
- Reset/sequential: RESET_PC=0, zero-wait memory, advance asserted whenever instr_valid=1, no control → imem_addr 0,4,8,12 on every other cycle; retired=3 after third retirement.
- Wait states: imem_ready held low 3 cycles → imem_req held high, addr unchanged, instr_valid=0 until cycle after ready; advance during FETCH has no effect on retired.
- Branch: pc=0x100, instr[15:0]=16'hFFFE, PCSrc=1 → next imem_addr=0x0FC. Jump: pc=0x1000_0040, instr[25:0]=26'h0000010 → 0x1000_0040.
- Priority: JR=1, Jump=1, PCSrc=1, rs_data=0x200 → next imem_addr=0x200.
- Fault: JR=1, rs_data=0x202 → pc=0x202, fault=1, imem_req=0 permanently; further advance/imem_ready ignored; reset clears fault and resumes fetch at RESET_PC.
- Async reset mid-wait and wrap: assert reset between edges in FETCH → imem_addr=RESET_PC at once. pc=32'hFFFF_FFFC with no control → next fetch at 0.
